token_double_sched: RTL and testbench

TOKEN_DOUBLE_SCHED -- requirements
Module: token_double_sched

---
 rtl/token_sched_pkg.sv | 13 +
 rtl/token_double_sched_if.sv | 15 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/token_double_sched.sv | 136 +++++++++++++
 tb/tb_token_double_sched.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/token_sched_pkg.sv
// Shared types and default sizing for the token doubling scheduler.
package token_sched_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int MAX_RUN_DEF = 200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/token_double_sched_if.sv
// Requester-side bundle of the token doubler: requests/tokens in, grant and status out.
interface token_double_sched_if #(
    parameter int N_REQ = token_sched_pkg::N_REQ_DEF
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] a;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] overflow;
    logic             b;
    logic             busy;
    logic             done;

    modport master (output req, a, input grant, overflow, b, busy, done);
    modport slave  (input req, a, output grant, overflow, b, busy, done);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin winner pick: first eligible index at or after i_ptr, wrapping at N_REQ-1.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_elig,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_win,
    output logic                     o_valid
);
    localparam int PW = $clog2(N_REQ);

    logic [PW:0] w_idx;

    always_comb begin
        o_win   = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(N_REQ)) begin
                w_idx = w_idx - (PW+1)'(N_REQ);
            end
            if (!o_valid && i_elig[w_idx[PW-1:0]]) begin
                o_win[w_idx[PW-1:0]] = 1'b1;
                o_valid              = 1'b1;
            end
        end
    end
endmodule

// File: rtl/token_double_sched.sv
// Shares one serial token doubler among N_REQ requesters with round-robin sessions.
// state | meaning
// IDLE  | no session; picks next eligible requester (b=0)
// GRANT | granted stream running; b = token | pending tokens
// DRAIN | requester gone; emit pending tokens as ones, then end
module token_double_sched
    import token_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int MAX_RUN = MAX_RUN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    token_double_sched_if.slave  bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_RUN + 1);

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic [N_REQ-1:0] r_ovf, w_ovf_nxt;
    logic [PW-1:0]    r_ptr, w_ptr_nxt;
    logic             r_busy, r_done, w_done_nxt;
    logic             r_arm;
    logic             w_b;

    logic [N_REQ-1:0] w_elig, w_win;
    logic             w_valid;
    logic [PW-1:0]    w_win_idx;
    logic             w_a_sel, w_req_g, w_cnt_nz;

    assign w_elig   = bus.req & ~r_ovf;
    assign w_a_sel  = |(r_grant & bus.a & bus.req);
    assign w_req_g  = |(r_grant & bus.req);
    assign w_cnt_nz = (r_cnt != '0);

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_win   (w_win),
        .o_valid (w_valid)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win[i]) w_win_idx = PW'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_ovf_nxt   = r_ovf;
        w_ptr_nxt   = r_ptr;
        w_done_nxt  = 1'b0;
        w_b         = 1'b0;
        case (r_state)
            IDLE: begin
                // r_arm holds off the first grant until the second edge after reset
                if (r_arm && w_valid) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = w_win;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = (w_win_idx == PW'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;
                end
            end
            GRANT: begin
                w_b = w_a_sel | w_cnt_nz;
                if (w_a_sel && (r_cnt == CW'(MAX_RUN))) begin
                    w_ovf_nxt   = r_ovf | r_grant;
                    w_cnt_nxt   = '0;
                    w_grant_nxt = '0;
                    w_state_nxt = IDLE;
                end else if (!w_req_g) begin
                    // cnt is held on the way into DRAIN so DRAIN emits exactly cnt ones
                    if (!w_cnt_nz) begin
                        w_grant_nxt = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end else if (w_a_sel) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else if (w_cnt_nz) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            DRAIN: begin
                w_b       = 1'b1;
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_grant_nxt = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_grant <= '0;
            r_ovf   <= '0;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_arm   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_ovf   <= w_ovf_nxt;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_done_nxt;
            r_arm   <= 1'b1;
        end
    end

    assign bus.grant    = r_grant;
    assign bus.overflow = r_ovf;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.b        = w_b;
endmodule

// File: tb/tb_token_double_sched.sv
// Directed bench for token_double_sched: vector table for one session plus corner sequences.
module tb_token_double_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    token_double_sched_if #(.N_REQ(4)) bus ();

    token_double_sched #(.N_REQ(4), .MAX_RUN(200)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] a;
        logic       b;
        logic [3:0] grant;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tv[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // leaves the bench at posedge+1 with rst just released (cycle c0)
    task automatic do_reset();
        rst = 1'b0;
        bus.req = '0;
        bus.a = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic vec_t mk(logic [3:0] rq, logic [3:0] aa, logic bb,
                                logic [3:0] gg, logic bs, logic dn);
        vec_t v;
        v.req = rq; v.a = aa; v.b = bb; v.grant = gg; v.busy = bs; v.done = dn;
        return v;
    endfunction

    initial begin
        logic [9:0] a_pat;
        logic [9:0] b_pat;
        logic [3:0] rr_exp[5];
        int         cnt_bad;

        a_pat = 10'b1001001100;
        b_pat = 10'b1101101111;
        tv[0] = mk(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        tv[1] = mk(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tv[2+i] = mk(4'b0001, {3'b000, a_pat[9-i]}, b_pat[9-i], 4'b0001, 1'b1, 1'b0);
        end
        tv[12] = mk(4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0);
        tv[13] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
        tv[14] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

        // reset state
        bus.req = 4'b1111;
        bus.a = 4'b1111;
        #2;
        chk("rst_grant", bus.grant, 4'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_b", bus.b, 1'b0);
        chk("rst_ovf", bus.overflow, 4'b0);

        // single-requester session from the table
        do_reset();
        for (int i = 0; i < 15; i++) begin
            bus.req = tv[i].req;
            bus.a = tv[i].a;
            #1;
            chk($sformatf("vec%0d_b", i), bus.b, tv[i].b);
            chk($sformatf("vec%0d_grant", i), bus.grant, tv[i].grant);
            chk($sformatf("vec%0d_busy", i), bus.busy, tv[i].busy);
            chk($sformatf("vec%0d_done", i), bus.done, tv[i].done);
            tick();
        end

        // round-robin order with one IDLE cycle between sessions
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        do_reset();
        bus.req = 4'b1111;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr%0d_grant", k), bus.grant, rr_exp[k]);
            chk($sformatf("rr%0d_busy", k), bus.busy, 1'b1);
            bus.req = 4'b1111 & ~rr_exp[k];
            tick();
            chk($sformatf("rr%0d_gap_grant", k), bus.grant, 4'b0);
            chk($sformatf("rr%0d_gap_done", k), bus.done, 1'b1);
            bus.req = 4'b1111;
            tick();
        end

        // overflow of requester 2 on the 201st consecutive one
        do_reset();
        bus.req = 4'b0100;
        tick();
        tick();
        chk("ovf_first_grant", bus.grant, 4'b0100);
        for (int i = 0; i < 201; i++) begin
            bus.a = 4'b0100;
            #1;
            chk($sformatf("ovf_b%0d", i), bus.b, 1'b1);
            if (i == 200) chk("ovf_grant_held", bus.grant, 4'b0100);
            tick();
        end
        chk("ovf_flag", bus.overflow, 4'b0100);
        chk("ovf_grant_drop", bus.grant, 4'b0);
        chk("ovf_busy", bus.busy, 1'b0);
        chk("ovf_no_done", bus.done, 1'b0);
        cnt_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.grant != 4'b0 || bus.busy) cnt_bad++;
        end
        chk("ovf_never_regranted", cnt_bad, 0);

        // drive every requester into overflow, then nothing is ever granted
        bus.req = 4'b1111;
        bus.a = 4'b1111;
        repeat (1000) tick();
        chk("all_ovf_flags", bus.overflow, 4'b1111);
        cnt_bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.busy || bus.b || bus.grant != 4'b0) cnt_bad++;
        end
        chk("all_ovf_idle", cnt_bad, 0);

        // drain: 5 pending ones emitted after req drops, a ignored
        do_reset();
        bus.req = 4'b0001;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.a = 4'b0001;
            #1;
            chk($sformatf("drn_in_b%0d", i), bus.b, 1'b1);
            tick();
        end
        bus.req = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            bus.a = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            #1;
            chk($sformatf("drn_b%0d", i), bus.b, 1'b1);
            chk($sformatf("drn_busy%0d", i), bus.busy, 1'b1);
            chk($sformatf("drn_done%0d", i), bus.done, 1'b0);
            tick();
        end
        bus.a = 4'b0000;
        #1;
        chk("drn_end_b", bus.b, 1'b0);
        chk("drn_end_done", bus.done, 1'b1);
        chk("drn_end_grant", bus.grant, 4'b0);
        chk("drn_end_busy", bus.busy, 1'b0);
        tick();

        // reset while draining with cnt=3
        do_reset();
        bus.req = 4'b0010;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.a = 4'b0010;
            tick();
        end
        bus.req = 4'b0000;
        bus.a = 4'b0000;
        tick();
        tick();
        tick();
        chk("rdrn_pre_busy", bus.busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("rdrn_grant", bus.grant, 4'b0);
        chk("rdrn_busy", bus.busy, 1'b0);
        chk("rdrn_b", bus.b, 1'b0);
        chk("rdrn_done", bus.done, 1'b0);
        chk("rdrn_ovf", bus.overflow, 4'b0);
        tick();
        chk("rdrn_done_held", bus.done, 1'b0);
        bus.req = 4'b1111;
        rst = 1'b1;
        tick();
        chk("rdrn_no_early_grant", bus.grant, 4'b0);
        tick();
        #1;
        chk("rdrn_next_grant", bus.grant, 4'b0001);
        chk("rdrn_pending_gone", bus.b, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
